deser_arbiter: RTL
==================

# deser_arbiter

Round-robin controller that shares one `DESERIALIZADOR` instance among `NUM_REQ` byte producers. It serializes the granted byte LSB-first into the deserializer, waits for `data_ready`, forwards the recovered byte plus source tag to the downstream queue, and closes the handshake with `ack_in`. It sits between the producers and the deserializer/queue pair in the 100 kHz domain.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `SRC_W`, `$clog2(NUM_REQ)`, source-tag width (derived, not overridden)

- `clock_100KHz`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  requester i holds a byte
- `req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- `req_grant`  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured
- `des_status`  in  1  deserializer `status_out`
- `des_data_in`  out  1  to deserializer `data_in`
- `des_write_in`  out  1  to deserializer `write_in`
- `des_data_ready`  in  1  deserializer `data_ready`
- `des_data_out`  in  8  deserializer `data_out`
- `des_ack`  out  1  to deserializer `ack_in`
- `q_full`  in  1  downstream queue full
- `q_push`  out  1  one-cycle push strobe
- `q_data`  out  8  byte pushed
- `q_src`  out  SRC_W  source tag of pushed byte
- `busy`  out  1  high in any state except IDLE
- `err_mismatch`  out  1  sticky compare error (only with `DESER_ARB_CHECK_EN`)

## Operation
- States: IDLE, SHIFT, WAIT_RDY.
- IDLE: if any `req_valid`, pick first valid index searching upward (wrapping) from `rr_ptr`; capture byte into `shreg`, tag into `src_q`; pulse `req_grant[i]`; `bit_cnt`<=0; `rr_ptr`<=i+1 mod NUM_REQ; go SHIFT. No valid: stay.
- SHIFT: `des_data_in`=`shreg[bit_cnt]`; `des_write_in`=`des_status`. On a cycle with `des_status`=1, `bit_cnt`++; on the 8th written bit (`bit_cnt`==7) go WAIT_RDY. `des_status`=0 stalls without losing position.
- WAIT_RDY: when `des_data_ready`=1 and `q_full`=0, assert `q_push`, `des_ack` together for exactly one cycle, `q_data`=`des_data_out`, `q_src`=`src_q`; go IDLE. Ready with `q_full`=1: hold, no ack, no push.
- `req_valid` changes during SHIFT/WAIT_RDY are ignored; captured byte is authoritative.
- Requester deasserting `req_valid` before grant simply loses arbitration; no partial capture.

## Timing
- Reset values: `req_grant`=0, `des_data_in`=0, `des_write_in`=0, `des_ack`=0, `q_push`=0, `q_data`=0, `q_src`=0, `busy`=0, `err_mismatch`=0; state IDLE, `rr_ptr`=0, `bit_cnt`=0.
- Grant cycle T; bits on T+1..T+8 (no stall); `des_data_ready` seen T+9; push/ack at T+9 if queue not full. Steady throughput: 10 cycles/byte.
- `des_write_in`, `des_data_in` combinational from state/`bit_cnt`/`des_status`; `q_push`/`des_ack` combinational in WAIT_RDY (Mealy), never high two consecutive cycles.
- Reset mid-operation: everything returns to reset values immediately; top level drives the deserializer reset from `~reset_n` so no partial byte survives.
- Simultaneous all-valid: strict rotation 0,1,…,NUM_REQ-1,0.

## Configuration
- `DESER_ARB_CHECK_EN` defined: at push cycle compare `des_data_out` against captured `shreg`; mismatch sets `err_mismatch` (sticky until reset). Undefined: compare logic absent, `err_mismatch` tied 0.

## Structure
- Package `deser_pkg`: state enum `arb_state_t` {IDLE, SHIFT, WAIT_RDY}, constant `BYTE_W`=8, function for round-robin next index.
- One natural sub-module: `rr_picker` (combinational, `req_valid` + `rr_ptr` -> valid flag + index).

## Test plan
- Single request: req0=0xA5 -> grant0 at T, `des_data_in` 1,0,1,0,0,1,0,1 on T+1..T+8, push 0xA5 src 0 at T+9.
- Both valid continuously, req0=0x11, req1=0x22 -> pushes alternate 0x11/0x22 with src 0/1, 10 cycles apart.
- `des_status` low 3 cycles mid-byte -> `des_write_in` low those cycles, byte still 0x3C intact, push delayed 3 cycles.
- `q_full`=1 when ready -> no push/ack, held; release after 5 cycles -> single push+ack next cycle.
- `reset_n` low during SHIFT bit 4 -> all outputs 0, state IDLE; next request 0x5A delivered correctly.
- With `DESER_ARB_CHECK_EN`, force `des_data_out`=0x00 for byte 0xFF -> `err_mismatch`=1, stays 1 after next good byte.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared types, constants and round-robin index helpers for the
// deser_arbiter block.
package deser_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2
    } arb_state_t;

    // Fold an index in [0, 2n) back into [0, n).
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        if (idx >= n) begin
            return idx - n;
        end else begin
            return idx;
        end
    endfunction

    // Round-robin successor of idx among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return rr_wrap(idx + 32'd1, n);
    endfunction

endpackage

// File: rtl/deser_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first valid
// requester found searching upward (with wrap) from rr_ptr_i.
module rr_picker
    import deser_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [SRC_W-1:0]   rr_ptr_i,
    output logic               any_valid_o,
    output logic [SRC_W-1:0]   pick_idx_o
);

    int unsigned best_s;
    int unsigned dist_s;

    // Pick the valid requester with the smallest rotational distance from the pointer.
    always_comb begin
        any_valid_o = 1'b0;
        pick_idx_o  = '0;
        best_s      = 32'(NUM_REQ);
        dist_s      = 32'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            dist_s = rr_wrap(32'(j) + 32'(NUM_REQ) - 32'(rr_ptr_i), 32'(NUM_REQ));
            if (req_valid_i[j] && (dist_s < best_s)) begin
                best_s      = dist_s;
                pick_idx_o  = SRC_W'(j);
                any_valid_o = 1'b1;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/deser_arbiter.sv
// deser_arbiter: round-robin sharing of one deserializer among NUM_REQ byte
// producers. The granted byte is shifted LSB-first into the deserializer, the
// recovered byte is pushed to the downstream queue with its source tag, and
// the deserializer handshake is closed with des_ack.
// Optional feature: define DESER_ARB_CHECK_EN to compare the recovered byte
// with the captured byte and raise a sticky err_mismatch on a difference.
// The deserializer is expected to be reset from ~reset_n by the enclosing
// level so that no partial byte survives a reset.
module deser_arbiter
    import deser_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                   clock_100KHz,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_grant,
    input  logic                   des_status,
    output logic                   des_data_in,
    output logic                   des_write_in,
    input  logic                   des_data_ready,
    input  logic [BYTE_W-1:0]      des_data_out,
    output logic                   des_ack,
    input  logic                   q_full,
    output logic                   q_push,
    output logic [BYTE_W-1:0]      q_data,
    output logic [SRC_W-1:0]       q_src,
    output logic                   busy,
    output logic                   err_mismatch
);

    arb_state_t          state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic                any_valid_s;
    logic [SRC_W-1:0]    pick_idx_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .any_valid_o (any_valid_s),
        .pick_idx_o  (pick_idx_s)
    );

    // State and datapath registers; async reset returns everything to idle.
    always_ff @(posedge clock_100KHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= '0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            src_q     <= src_d;
        end
    end

    // Next-state logic and Mealy outputs for grant, bit shifting and push/ack.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        src_d        = src_q;
        req_grant    = '0;
        des_data_in  = 1'b0;
        des_write_in = 1'b0;
        des_ack      = 1'b0;
        q_push       = 1'b0;
        q_data       = '0;
        q_src        = '0;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (pick_idx_s == SRC_W'(j)) begin
                            req_grant[j] = 1'b1;
                            shreg_d      = req_data[j*BYTE_W +: BYTE_W];
                        end else begin
                            req_grant[j] = 1'b0;
                        end
                    end
                    src_d     = pick_idx_s;
                    bit_cnt_d = 3'd0;
                    rr_ptr_d  = SRC_W'(rr_next(32'(pick_idx_s), 32'(NUM_REQ)));
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                des_data_in  = shreg_q[bit_cnt_q];
                des_write_in = des_status;
                if (des_status) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = WAIT_RDY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    // Deserializer not accepting: hold the bit position.
                    bit_cnt_d = bit_cnt_q;
                end
            end
            WAIT_RDY: begin
                if (des_data_ready && !q_full) begin
                    q_push  = 1'b1;
                    des_ack = 1'b1;
                    q_data  = des_data_out;
                    q_src   = src_q;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

`ifdef DESER_ARB_CHECK_EN
    logic err_q;

    // Sticky flag: recovered byte differs from the byte that was shifted in.
    always_ff @(posedge clock_100KHz or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (q_push && (des_data_out != shreg_q)) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign err_mismatch = err_q;
`else
    assign err_mismatch = 1'b0;
`endif

endmodule
